// File: rtl/dual_cmos_sync_ctrl.sv
// ---------------------------------------------------------------------------
// dual_cmos_sync_ctrl
//
// Frame/line scheduler for the dual-camera merge path. Each camera writes into
// its own line FIFO; this block waits for both vsyncs, measures their skew,
// emits a merged frame-start pulse, then drains both FIFOs in lock-step, one
// H_ACTIVE-word burst per line, with at least H_GAP idle cycles in between.
// Loss of sync (skew overflow, line-wait timeout, vsync mid-frame) sets a
// sticky error flag.
//
// Ports
//   sys_clk        single clock; every input is already synchronous to it
//   rst            asynchronous, active-high reset
//   enable         run; low returns the scheduler to IDLE at the next edge
//   cam0_vsync     camera 0 vsync level (high = frame start)
//   cam1_vsync     camera 1 vsync level
//   cam0_line_rdy  FIFO0 holds at least one full line
//   cam1_line_rdy  FIFO1 holds at least one full line
//   err_clr        single-cycle pulse clearing sync_err
//   rd_en0/rd_en1  FIFO read enables (always identical)
//   out_vsync      merged frame-start pulse, VS_LEN cycles wide
//   out_href       merged line-valid: rd_en delayed by RD_LAT cycles
//   skew_val       last measured vsync rise skew between cameras, cycles
//   sync_err       sticky loss-of-sync flag
//   line_idx       current line within the frame
// ---------------------------------------------------------------------------
module dual_cmos_sync_ctrl #(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768,
    parameter int H_GAP    = 16,
    parameter int VS_LEN   = 8,
    parameter int SKEW_W   = 16,
    parameter int TMO_W    = 20,
    parameter int RD_LAT   = 1
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cam0_vsync,
    input  logic              cam1_vsync,
    input  logic              cam0_line_rdy,
    input  logic              cam1_line_rdy,
    input  logic              err_clr,
    output logic              rd_en0,
    output logic              rd_en1,
    output logic              out_vsync,
    output logic              out_href,
    output logic [SKEW_W-1:0] skew_val,
    output logic              sync_err,
    output logic [9:0]        line_idx
);

    // One shared phase counter times the VSYNC pulse, the READ burst and the GAP.
    localparam int CNT_W = $clog2(H_ACTIVE + H_GAP + VS_LEN + 1);
    localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(VS_LEN - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(H_GAP - 1);
    localparam logic [9:0]       LINE_LAST = 10'(V_ACTIVE - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_V     = 3'd1;
    localparam logic [2:0] S_WAIT_OTHER = 3'd2;
    localparam logic [2:0] S_VSYNC      = 3'd3;
    localparam logic [2:0] S_WAIT_LINE  = 3'd4;
    localparam logic [2:0] S_READ       = 3'd5;
    localparam logic [2:0] S_GAP        = 3'd6;

    logic [2:0]        state, state_nxt;
    logic              vs0_d, vs1_d;
    logic              rise0, rise1, any_rise, both_rise, other_rise;
    logic              first_cam;          // 1: camera 1 rose first
    logic              in_frame, both_rdy;
    logic              skew_ovf, tmo_ovf, restart, err_set, vs_start, line_done;
    logic [SKEW_W-1:0] skew_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [CNT_W-1:0]  phase_cnt;
    logic              rd_en_r;
    logic [RD_LAT-1:0] href_sr;

    assign rise0      = cam0_vsync & ~vs0_d;
    assign rise1      = cam1_vsync & ~vs1_d;
    assign any_rise   = rise0 | rise1;
    assign both_rise  = rise0 & rise1;
    assign other_rise = first_cam ? rise0 : rise1;
    assign both_rdy   = cam0_line_rdy & cam1_line_rdy;

    assign in_frame = (state == S_VSYNC) || (state == S_WAIT_LINE) ||
                      (state == S_READ)  || (state == S_GAP);

    assign skew_ovf = (state == S_WAIT_OTHER) && !other_rise && (skew_cnt == '1);
    assign tmo_ovf  = (state == S_WAIT_LINE) && !both_rdy && (tmo_cnt == '1);

    // A vsync edge inside a frame aborts it and starts a new alignment.
    assign restart   = enable && in_frame && any_rise;
    assign err_set   = enable && (skew_ovf || tmo_ovf || restart);
    assign vs_start  = (state_nxt == S_VSYNC) && ((state != S_VSYNC) || restart);
    assign line_done = enable && !restart && (state == S_GAP) && (phase_cnt == GAP_LAST);

    // NOTE: state_nxt is given a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else if (restart) begin
            state_nxt = both_rise ? S_VSYNC : S_WAIT_OTHER;
        end else begin
            case (state)
                S_IDLE:       state_nxt = S_WAIT_V;
                S_WAIT_V: begin
                    if (both_rise)     state_nxt = S_VSYNC;
                    else if (any_rise) state_nxt = S_WAIT_OTHER;
                end
                S_WAIT_OTHER: begin
                    if (other_rise)    state_nxt = S_VSYNC;
                    else if (skew_ovf) state_nxt = S_WAIT_V;
                end
                S_VSYNC:      if (phase_cnt == VS_LAST) state_nxt = S_WAIT_LINE;
                S_WAIT_LINE: begin
                    if (both_rdy)      state_nxt = S_READ;
                    else if (tmo_ovf)  state_nxt = S_WAIT_V;
                end
                S_READ:       if (phase_cnt == RD_LAST) state_nxt = S_GAP;
                S_GAP: begin
                    if (phase_cnt == GAP_LAST)
                        state_nxt = (line_idx == LINE_LAST) ? S_WAIT_V : S_WAIT_LINE;
                end
                default:      state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            vs0_d     <= 1'b0;
            vs1_d     <= 1'b0;
            first_cam <= 1'b0;
            skew_cnt  <= '0;
            tmo_cnt   <= '0;
            phase_cnt <= '0;
            rd_en_r   <= 1'b0;
            href_sr   <= '0;
            out_vsync <= 1'b0;
            skew_val  <= '0;
            sync_err  <= 1'b0;
            line_idx  <= '0;
        end else begin
            vs0_d     <= cam0_vsync;
            vs1_d     <= cam1_vsync;
            state     <= state_nxt;
            rd_en_r   <= (state_nxt == S_READ);
            out_vsync <= (state_nxt == S_VSYNC);
            // Read-latency pipe; keeps shifting after enable drops so the tail drains.
            href_sr   <= RD_LAT'({href_sr, rd_en_r});

            // Both wait counters restart from zero on every entry to their state.
            skew_cnt <= (state == S_WAIT_OTHER) ? skew_cnt + 1'b1 : '0;
            tmo_cnt  <= (state == S_WAIT_LINE)  ? tmo_cnt + 1'b1  : '0;

            if ((state_nxt != state) || restart)
                phase_cnt <= '0;
            else if ((state == S_VSYNC) || (state == S_READ) || (state == S_GAP))
                phase_cnt <= phase_cnt + 1'b1;
            else
                phase_cnt <= '0;

            if ((state_nxt == S_WAIT_OTHER) && (state != S_WAIT_OTHER))
                first_cam <= rise1 & ~rise0;

            if (vs_start)
                skew_val <= (state == S_WAIT_OTHER) ? skew_cnt + 1'b1 : '0;

            if (err_set)
                sync_err <= 1'b1;
            else if (err_clr)
                sync_err <= 1'b0;

            if (vs_start)
                line_idx <= '0;
            else if (line_done)
                line_idx <= (line_idx == LINE_LAST) ? '0 : line_idx + 1'b1;
        end
    end

    assign rd_en0   = rd_en_r;
    assign rd_en1   = rd_en_r;
    assign out_href = href_sr[RD_LAT-1];

endmodule

// File: tb/tb_dual_cmos_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dual_cmos_sync_ctrl
//
// Scoreboard bench for dual_cmos_sync_ctrl with a small frame geometry
// (8 pixels x 4 lines, 2-cycle gap, 8-cycle vsync, 6-bit skew and timeout
// counters, 3-cycle read latency). Stimulus pushes the expected vsync pulses,
// read bursts and href bursts into queues; a monitor measures each burst as
// it completes and compares it with the head of the matching queue.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dual_cmos_sync_ctrl;

    localparam int H_ACTIVE = 8;
    localparam int V_ACTIVE = 4;
    localparam int H_GAP    = 2;
    localparam int VS_LEN   = 8;
    localparam int SKEW_W   = 6;
    localparam int TMO_W    = 6;
    localparam int RD_LAT   = 3;

    logic              sys_clk       = 1'b0;
    logic              rst           = 1'b1;
    logic              enable        = 1'b0;
    logic              cam0_vsync    = 1'b0;
    logic              cam1_vsync    = 1'b0;
    logic              cam0_line_rdy = 1'b0;
    logic              cam1_line_rdy = 1'b0;
    logic              err_clr       = 1'b0;
    logic              rd_en0, rd_en1, out_vsync, out_href, sync_err;
    logic [SKEW_W-1:0] skew_val;
    logic [9:0]        line_idx;

    always #5 sys_clk = ~sys_clk;

    dual_cmos_sync_ctrl #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_GAP(H_GAP), .VS_LEN(VS_LEN),
        .SKEW_W(SKEW_W), .TMO_W(TMO_W), .RD_LAT(RD_LAT)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .enable       (enable),
        .cam0_vsync   (cam0_vsync),
        .cam1_vsync   (cam1_vsync),
        .cam0_line_rdy(cam0_line_rdy),
        .cam1_line_rdy(cam1_line_rdy),
        .err_clr      (err_clr),
        .rd_en0       (rd_en0),
        .rd_en1       (rd_en1),
        .out_vsync    (out_vsync),
        .out_href     (out_href),
        .skew_val     (skew_val),
        .sync_err     (sync_err),
        .line_idx     (line_idx)
    );

    typedef struct {
        int len;
        int aux;   // vsync: skew_val, rd: line_idx, href: lag behind rd_en
    } burst_t;

    burst_t exp_vs[$];
    burst_t exp_rd[$];
    burst_t exp_hr[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input int len);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected burst of %0d cycles, nothing expected", name, len);
    endtask

    task automatic push_vs(input int skew);
        burst_t b;
        b.len = VS_LEN;
        b.aux = skew;
        exp_vs.push_back(b);
    endtask

    task automatic push_rd(input int len, input int idx);
        burst_t b;
        b.len = len;
        b.aux = idx;
        exp_rd.push_back(b);
    endtask

    task automatic push_hr(input int len);
        burst_t b;
        b.len = len;
        b.aux = RD_LAT;
        exp_hr.push_back(b);
    endtask

    task automatic push_line(input int len, input int idx);
        push_rd(len, idx);
        push_hr(len);
    endtask

    task automatic push_frame(input int skew);
        push_vs(skew);
        for (int i = 0; i < V_ACTIVE; i++) push_line(H_ACTIVE, i);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_vs.size() + exp_rd.size() + exp_hr.size()) != 0 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check("drain_pending", exp_vs.size() + exp_rd.size() + exp_hr.size(), 0);
        step(4);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        step(1);
    endtask

    // Monitor: measures bursts on the falling edge, away from the active edge.
    int cyc      = 0;
    int vs_len   = 0;
    int rd_len   = 0;
    int rd1_len  = 0;
    int rd_idx   = 0;
    int rd_start = 0;
    int hr_len   = 0;
    int hr_lag   = 0;

    always @(negedge sys_clk) begin
        burst_t b;
        cyc++;

        if (out_vsync === 1'b1) begin
            vs_len++;
        end else if (vs_len > 0) begin
            if (exp_vs.size() == 0) unexpected("vsync", vs_len);
            else begin
                b = exp_vs.pop_front();
                check("vsync_width", vs_len, b.len);
                check("skew_val", 32'(skew_val), b.aux);
            end
            vs_len = 0;
        end

        if (rd_en1 === 1'b1) rd1_len++;
        if (rd_en0 === 1'b1) begin
            if (rd_len == 0) begin
                rd_idx   = int'(line_idx);
                rd_start = cyc;
            end
            rd_len++;
        end else if (rd_len > 0) begin
            if (exp_rd.size() == 0) unexpected("rd_en", rd_len);
            else begin
                b = exp_rd.pop_front();
                check("rd_len", rd_len, b.len);
                check("rd_en1_len", rd1_len, b.len);
                check("line_idx", rd_idx, b.aux);
            end
            rd_len  = 0;
            rd1_len = 0;
        end

        if (out_href === 1'b1) begin
            if (hr_len == 0) hr_lag = cyc - rd_start;
            hr_len++;
        end else if (hr_len > 0) begin
            if (exp_hr.size() == 0) unexpected("href", hr_len);
            else begin
                b = exp_hr.pop_front();
                check("href_len", hr_len, b.len);
                check("href_lag", hr_lag, b.aux);
            end
            hr_len = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        step(2);
        check("rst_rd_en0", rd_en0, 0);
        check("rst_rd_en1", rd_en1, 0);
        check("rst_out_vsync", out_vsync, 0);
        check("rst_out_href", out_href, 0);
        check("rst_skew_val", 32'(skew_val), 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_line_idx", 32'(line_idx), 0);
        rst           = 1'b0;
        enable        = 1'b1;
        cam0_line_rdy = 1'b1;
        cam1_line_rdy = 1'b1;
        step(3);

        // 1: both vsyncs in the same cycle -> skew 0, four full lines
        push_frame(0);
        cam0_vsync = 1'b1;
        cam1_vsync = 1'b1;
        step(2);
        cam0_vsync = 1'b0;
        cam1_vsync = 1'b0;
        wait_drain(300);
        check("t1_sync_err", sync_err, 0);

        // 2: cam1 rises 37 cycles after cam0
        push_frame(37);
        cam0_vsync = 1'b1;
        step(2);
        cam0_vsync = 1'b0;
        step(35);
        cam1_vsync = 1'b1;
        step(2);
        cam1_vsync = 1'b0;
        wait_drain(300);
        check("t2_sync_err", sync_err, 0);

        // 3: cam1 never rises -> overflow once the 6-bit counter is all ones
        cam0_vsync = 1'b1;
        step(2);
        cam0_vsync = 1'b0;
        step(58);
        check("t3_err_before_ovf", sync_err, 0);
        step(10);
        check("t3_err_after_ovf", sync_err, 1);
        check("t3_skew_kept", 32'(skew_val), 37);
        check("t3_no_vsync", out_vsync, 0);
        pulse_err_clr();
        check("t3_err_cleared", sync_err, 0);

        // 4: cam0_line_rdy low before line 2 -> timeout after 64 waiting cycles
        push_vs(0);
        push_line(H_ACTIVE, 0);
        push_line(H_ACTIVE, 1);
        cam0_vsync = 1'b1;
        cam1_vsync = 1'b1;
        step(2);
        cam0_vsync = 1'b0;
        cam1_vsync = 1'b0;
        step(22);
        cam0_line_rdy = 1'b0;
        step(26);
        check("t4_line_idx_wait", 32'(line_idx), 2);
        step(40);
        check("t4_err_before_tmo", sync_err, 0);
        step(10);
        check("t4_err_after_tmo", sync_err, 1);
        cam0_line_rdy = 1'b1;
        wait_drain(50);
        pulse_err_clr();
        check("t4_err_cleared", sync_err, 0);

        // 5: cam0 vsync mid-READ of line 0 (with err_clr in the same cycle),
        //    cam1 follows 5 cycles later and a fresh frame runs
        push_vs(0);
        push_line(3, 0);
        push_frame(5);
        cam0_vsync = 1'b1;
        cam1_vsync = 1'b1;
        step(2);
        cam0_vsync = 1'b0;
        cam1_vsync = 1'b0;
        step(10);
        cam0_vsync = 1'b1;
        err_clr    = 1'b1;
        step(1);
        err_clr    = 1'b0;
        check("t5_err_set_priority", sync_err, 1);
        step(1);
        cam0_vsync = 1'b0;
        step(3);
        cam1_vsync = 1'b1;
        step(2);
        cam1_vsync = 1'b0;
        wait_drain(300);
        check("t5_err_sticky", sync_err, 1);
        pulse_err_clr();
        check("t5_err_cleared", sync_err, 0);

        // 6: reset in the middle of line 1
        push_vs(0);
        push_line(H_ACTIVE, 0);
        push_rd(4, 1);
        push_hr(1);
        cam0_vsync = 1'b1;
        cam1_vsync = 1'b1;
        step(2);
        cam0_vsync = 1'b0;
        cam1_vsync = 1'b0;
        step(22);
        #2 rst = 1'b1;
        #1;
        check("t6_rd_en0", rd_en0, 0);
        check("t6_rd_en1", rd_en1, 0);
        check("t6_out_href", out_href, 0);
        check("t6_out_vsync", out_vsync, 0);
        check("t6_line_idx", 32'(line_idx), 0);
        check("t6_skew_val", 32'(skew_val), 0);
        step(2);
        rst = 1'b0;
        wait_drain(20);
        check("t6_idle_after_rst", rd_en0, 0);

        // 7: enable dropped during line 2 -> burst cut, href tail drains
        push_vs(0);
        push_line(H_ACTIVE, 0);
        push_line(H_ACTIVE, 1);
        push_line(3, 2);
        cam0_vsync = 1'b1;
        cam1_vsync = 1'b1;
        step(2);
        cam0_vsync = 1'b0;
        cam1_vsync = 1'b0;
        step(32);
        enable = 1'b0;
        wait_drain(50);
        check("t7_href_drained", out_href, 0);
        check("t7_sync_err", sync_err, 0);
        enable = 1'b1;
        step(5);

        check("final_rd_en1_idle", rd1_len, 0);
        check("final_queues", exp_vs.size() + exp_rd.size() + exp_hr.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
